// File: rtl/dly_pkg.sv
// rtl/dly_pkg.sv - shared state type, width helper and default parameters for dly_line_prog
package dly_pkg;

  localparam int DLY_DEF_CH          = 4;
  localparam int DLY_DEF_DATA_LENGTH = 8;
  localparam int DLY_DEF_MAX_DEPTH   = 32;
  localparam int DLY_DEF_DEF_DEPTH   = 19;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } dly_state_e;

  function automatic int dly_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dly_ram.sv
// rtl/dly_ram.sv - simple dual-port delay storage, synchronous write, combinational read
module dly_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 33,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dly_line_prog.sv
// rtl/dly_line_prog.sv - programmable multi-channel delay line with FILL masking
// Optional out-of-range flag: define DLY_LINE_CFG_CHECK_EN.
module dly_line_prog
  import dly_pkg::*;
#(
  parameter int CH          = DLY_DEF_CH,
  parameter int DATA_LENGTH = DLY_DEF_DATA_LENGTH,
  parameter int MAX_DEPTH   = DLY_DEF_MAX_DEPTH,
  parameter int DEF_DEPTH   = DLY_DEF_DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ce,
  input  logic [CH*DATA_LENGTH-1:0]     din,
  input  logic                          din_valid,
  input  logic [dly_clog2(MAX_DEPTH):0] del_cfg,
  input  logic                          del_load,
  output logic [CH*DATA_LENGTH-1:0]     dout,
  output logic                          dout_valid,
  output logic                          busy,
  output logic                          cfg_err
);

  localparam int DW = CH * DATA_LENGTH;
  localparam int AW = dly_clog2(MAX_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] MAX_D = CW'(MAX_DEPTH);

  dly_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] d_q, d_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic [CW-1:0] cfg_clamped;
  logic [AW-1:0] rd_addr;
  logic [DW:0]   rd_data;
  logic [DW:0]   tap;

  dly_ram #(
    .DEPTH (MAX_DEPTH),
    .WIDTH (DW + 1),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ce),
    .waddr (wptr_q),
    .wdata ({din_valid, din}),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Entry written D-1 ce edges ago; D=1 is the sample being written right now.
  assign rd_addr = wptr_q + AW'(1) - AW'(d_q);
  assign tap     = (d_q == CW'(1)) ? {din_valid, din} : rd_data;

  always_comb begin
    cfg_clamped = del_cfg;
    if (del_cfg == '0)        cfg_clamped = CW'(1);
    else if (del_cfg > MAX_D) cfg_clamped = MAX_D;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    d_d          = d_q;
    wptr_d       = wptr_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (ce) wptr_d = wptr_q + AW'(1);
    if (del_load) begin
      d_d          = cfg_clamped;
      cnt_d        = '0;
      state_d      = ST_FILL;
      dout_valid_d = 1'b0;
    end else if (ce) begin
      if (state_q == ST_FILL) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_d == d_q) state_d = ST_RUN;
      end
      // Data is only refreshed in RUN so dout holds its last value during FILL.
      if (state_d == ST_RUN) begin
        dout_d       = tap[DW-1:0];
        dout_valid_d = tap[DW];
      end else begin
        dout_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FILL;
      cnt_q        <= '0;
      d_q          <= CW'(DEF_DEPTH);
      wptr_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      d_q          <= d_d;
      wptr_q       <= wptr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

`ifdef DLY_LINE_CFG_CHECK_EN
  logic cfg_err_q, cfg_err_d;

  always_comb begin
    cfg_err_d = cfg_err_q;
    if (del_load) cfg_err_d = (del_cfg > MAX_D);
  end

  always_ff @(posedge clk) begin
    if (rst) cfg_err_q <= 1'b0;
    else     cfg_err_q <= cfg_err_d;
  end

  assign cfg_err = cfg_err_q;
`else
  assign cfg_err = 1'b0;
`endif

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q == ST_FILL);

endmodule

// File: tb/tb_dly_line_prog.sv
// tb/tb_dly_line_prog.sv - randomized self-checking bench for dly_line_prog against a history-queue model
module tb_dly_line_prog;

  localparam int CH   = 4;
  localparam int DL   = 8;
  localparam int MAXD = 32;
  localparam int DW   = CH * DL;

  logic          clk = 1'b0;
  logic          rst, ce, din_valid, del_load;
  logic [DW-1:0] din;
  logic [5:0]    del_cfg;
  logic [DW-1:0] dout;
  logic          dout_valid, busy, cfg_err;

  int errors = 0;
  int checks = 0;

  int            m_d, m_fill;
  bit            m_run;
  logic [DW-1:0] m_dout;
  logic          m_v, m_err;
  logic [DW:0]   hist[$];

  always #5 clk = ~clk;

  dly_line_prog #(
    .CH          (CH),
    .DATA_LENGTH (DL),
    .MAX_DEPTH   (MAXD),
    .DEF_DEPTH   (19)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .din        (din),
    .din_valid  (din_valid),
    .del_cfg    (del_cfg),
    .del_load   (del_load),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  function automatic int clamp_d(input int cfg);
    if (cfg < 1) return 1;
    if (cfg > MAXD) return MAXD;
    return cfg;
  endfunction

  // One clock: drive on negedge, advance the model at posedge, settle 1 time unit.
  task automatic step(input logic r, input logic c, input logic [DW-1:0] d,
                      input logic v, input logic l, input logic [5:0] cfg);
    logic [DW:0] e;
    @(negedge clk);
    rst = r; ce = c; din = d; din_valid = v; del_load = l; del_cfg = cfg;
    @(posedge clk);
    if (r) begin
      m_d = 19; m_fill = 0; m_run = 0; m_dout = '0; m_v = 0; m_err = 0;
      hist.delete();
    end else begin
      if (c) begin
        hist.push_back({v, d});
        if (hist.size() > 40) void'(hist.pop_front());
      end
      if (l) begin
        m_d = clamp_d(int'(cfg)); m_fill = 0; m_run = 0; m_v = 0;
`ifdef DLY_LINE_CFG_CHECK_EN
        m_err = (int'(cfg) > MAXD);
`endif
      end else if (c) begin
        if (!m_run) begin
          m_fill++;
          if (m_fill == m_d) m_run = 1;
        end
        if (m_run) begin
          e = hist[hist.size() - m_d];
          m_dout = e[DW-1:0];
          m_v = e[DW];
        end else begin
          m_v = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset;
    step(1, 1, $urandom(), 1, 0, 6'd0);
    checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout got=%h exp=0", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got=%b exp=0", dout_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
  endtask

  task automatic test_default_delay;
    logic [7:0] b;
    logic [7:0] eb;
    for (int i = 1; i <= 25; i++) begin
      b = 8'(i);
      step(0, 1, {4{b}}, 1, 0, 6'd0);
      checks++;
      if (dout_valid !== (i >= 19)) begin
        errors++; $display("FAIL default_valid edge=%0d got=%b exp=%b", i, dout_valid, (i >= 19));
      end
      checks++;
      if (busy !== (i < 19)) begin
        errors++; $display("FAIL default_busy edge=%0d got=%b exp=%b", i, busy, (i < 19));
      end
      if (i >= 19) begin
        eb = 8'(i - 18);
        checks++;
        if (dout !== {4{eb}}) begin
          errors++; $display("FAIL default_dout edge=%0d got=%h exp=%h", i, dout, {4{eb}});
        end
      end
    end
  endtask

  task automatic test_reprogram;
    logic [DW-1:0] sent[16];
    int busy_cnt;
    busy_cnt = 0;
    step(0, 1, $urandom(), 1, 1, 6'd5);
    if (busy === 1'b1) busy_cnt++;
    for (int k = 1; k <= 12; k++) begin
      sent[k] = $urandom();
      step(0, 1, sent[k], 1, 0, 6'd0);
      if (busy === 1'b1) busy_cnt++;
      checks++;
      if (dout_valid !== (k >= 5)) begin
        errors++; $display("FAIL reprog_valid edge=%0d got=%b exp=%b", k, dout_valid, (k >= 5));
      end
      if (k >= 5) begin
        checks++;
        if (dout !== sent[k-4]) begin
          errors++; $display("FAIL reprog_dout edge=%0d got=%h exp=%h", k, dout, sent[k-4]);
        end
      end
    end
    checks++;
    if (busy_cnt != 5) begin errors++; $display("FAIL reprog_busy_cycles got=%0d exp=5", busy_cnt); end
  endtask

  task automatic test_stall;
    logic          pat[5];
    logic [DW-1:0] prev_dout;
    logic          prev_v;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    step(0, 1, $urandom(), 1, 1, 6'd3);
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 5; j++) begin
        prev_dout = dout; prev_v = dout_valid;
        step(0, pat[j], $urandom(), 1'($urandom()), 0, 6'd0);
        if (!pat[j]) begin
          checks++;
          if (dout !== prev_dout || dout_valid !== prev_v) begin
            errors++; $display("FAIL stall_frozen got=%h/%b exp=%h/%b", dout, dout_valid, prev_dout, prev_v);
          end
        end
        checks++;
        if (dout_valid !== m_v || busy !== !m_run) begin
          errors++; $display("FAIL stall_ctrl got=%b/%b exp=%b/%b", dout_valid, busy, m_v, !m_run);
        end
        if (m_run) begin
          checks++;
          if (dout !== m_dout) begin errors++; $display("FAIL stall_dout got=%h exp=%h", dout, m_dout); end
        end
      end
    end
  endtask

  task automatic test_clamp;
    logic [DW-1:0] d;
    logic          exp_err;
    step(0, 0, $urandom(), 0, 1, 6'd0);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL clamp0_err got=%b exp=0", cfg_err); end
    d = $urandom();
    step(0, 1, d, 1, 0, 6'd0);
    checks++;
    if (dout !== d || dout_valid !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL clamp0_d1 got=%h/%b/%b exp=%h/1/0", dout, dout_valid, busy, d);
    end
    step(0, 1, $urandom(), 1, 1, 6'd40);
`ifdef DLY_LINE_CFG_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    checks++; if (cfg_err !== exp_err) begin errors++; $display("FAIL clamp40_err got=%b exp=%b", cfg_err, exp_err); end
    for (int k = 1; k <= 32; k++) begin
      step(0, 1, $urandom(), 1, 0, 6'd0);
      if (k >= 31) begin
        checks++;
        if (busy !== (k < 32)) begin errors++; $display("FAIL clamp40_busy edge=%0d got=%b exp=%b", k, busy, (k < 32)); end
      end
    end
    step(0, 1, $urandom(), 1, 1, 6'd8);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL clamp8_err got=%b exp=0", cfg_err); end
  endtask

  task automatic test_wrap;
    logic [DW-1:0] sent[101];
    logic          vs[101];
    step(0, 1, $urandom(), 1, 1, 6'd32);
    for (int i = 1; i <= 100; i++) begin
      sent[i] = $urandom();
      vs[i] = ((i - 1) % 4) != 1;
      step(0, 1, sent[i], vs[i], 0, 6'd0);
      if (i >= 32) begin
        checks++;
        if (dout_valid !== vs[i-31] || dout !== sent[i-31]) begin
          errors++; $display("FAIL wrap edge=%0d got=%h/%b exp=%h/%b", i, dout, dout_valid, sent[i-31], vs[i-31]);
        end
      end else begin
        checks++;
        if (dout_valid !== 1'b0) begin errors++; $display("FAIL wrap_fill edge=%0d got=%b exp=0", i, dout_valid); end
      end
    end
  endtask

  task automatic test_priority;
    step(0, 1, $urandom(), 1, 1, 6'd40);
    step(1, 1, $urandom(), 1, 1, 6'd7);
    checks++;
    if (busy !== 1'b1 || cfg_err !== 1'b0 || dout !== '0 || dout_valid !== 1'b0) begin
      errors++; $display("FAIL prio_state got=%b/%b/%h/%b exp=1/0/0/0", busy, cfg_err, dout, dout_valid);
    end
    for (int k = 1; k <= 20; k++) begin
      step(0, 1, $urandom(), 1, 0, 6'd0);
      if (k >= 7) begin
        checks++;
        if (dout_valid !== (k >= 19)) begin
          errors++; $display("FAIL prio_delay edge=%0d got=%b exp=%b", k, dout_valid, (k >= 19));
        end
      end
    end
  endtask

  task automatic test_random;
    logic r, c, l;
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 19) == 0);
      step(r, c, $urandom(), 1'($urandom()), l, 6'($urandom_range(0, 40)));
      checks++;
      if (dout_valid !== m_v || busy !== !m_run || cfg_err !== m_err) begin
        errors++; $display("FAIL random_ctrl n=%0d got=%b/%b/%b exp=%b/%b/%b", n, dout_valid, busy, cfg_err, m_v, !m_run, m_err);
      end
      if (m_run) begin
        checks++;
        if (dout !== m_dout) begin errors++; $display("FAIL random_dout n=%0d got=%h exp=%h", n, dout, m_dout); end
      end
    end
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0; din = '0; din_valid = 1'b0; del_load = 1'b0; del_cfg = '0;
    test_reset;
    test_default_delay;
    test_reprogram;
    test_stall;
    test_clamp;
    test_wrap;
    test_priority;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
